// File: rtl/ifu_isram.sv
// Instruction SRAM slave for the IFU: accepts one fetch address at a time on the
// AR channel, answers on the R channel after a fixed LATENCY, and holds until accepted.
module ifu_isram #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1,
  localparam int         AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_ar_valid,
  output logic          o_ar_ready,
  input  logic [31:0]   i_ar_addr,
  output logic          o_r_valid,
  input  logic          i_r_ready,
  output logic [31:0]   o_r_data,
  output logic          o_r_err,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_idx,
  input  logic [31:0]   i_ld_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_valid;
  logic [31:0] r_data;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic [29:0]   w_wordOff;
  logic [AW-1:0] w_idx;
  logic          w_oob;
  logic          w_fault;

  // Word offset from BASE; addresses below BASE wrap to a huge offset and fault.
  assign w_wordOff = r_addr[31:2] - BASE[31:2];
  assign w_idx     = w_wordOff[AW-1:0];
  assign w_oob     = |w_wordOff[29:AW];
  assign w_fault   = (r_addr[1:0] != 2'b00) || w_oob;

  assign o_ar_ready = (r_state == S_IDLE);
  assign o_r_valid  = r_valid;
  assign o_r_data   = r_data;
  assign o_r_err    = r_err;

  // Image contents survive reset so a reset does not force a reload.
  always_ff @(posedge clk) begin
    if (i_ld_en) begin
      r_mem[i_ld_idx] <= i_ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_valid <= 1'b0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_ar_valid) begin
            r_addr  <= i_ar_addr;
            r_cnt   <= LAT_M1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A preload landing on this same edge is not seen: the read uses the old word.
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_valid <= 1'b1;
            r_err   <= w_fault;
            r_data  <= w_fault ? 32'd0 : r_mem[w_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_r_ready) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_isram.sv
// Scoreboard bench for ifu_isram: three instances (LATENCY 1, 2, 4) driven by directed
// and random fetches; a negedge monitor checks every R beat against a reference model.
module tb_ifu_isram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          NI    = 3;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        err;
    int          riseCyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        arValid [NI];
  logic        arReady [NI];
  logic [31:0] arAddr  [NI];
  logic        rValid  [NI];
  logic        rReady  [NI];
  logic [31:0] rData   [NI];
  logic        rErr    [NI];
  logic        ldEn    [NI];
  logic [9:0]  ldIdx   [NI];
  logic [31:0] ldData  [NI];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit rndReady   = 1'b0;

  logic [31:0] model [NI][DEPTH];
  exp_t        sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : gDut
    ifu_isram #(
      .BASE   (BASE),
      .DEPTH  (DEPTH),
      .LATENCY((g == 0) ? 1 : (g == 1) ? 2 : 4)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_ar_valid(arValid[g]),
      .o_ar_ready(arReady[g]),
      .i_ar_addr (arAddr[g]),
      .o_r_valid (rValid[g]),
      .i_r_ready (rReady[g]),
      .o_r_data  (rData[g]),
      .o_r_err   (rErr[g]),
      .i_ld_en   (ldEn[g]),
      .i_ld_idx  (ldIdx[g]),
      .i_ld_data (ldData[g])
    );
  end

  function automatic int latOf(input int inst);
    return (inst == 0) ? 1 : (inst == 1) ? 2 : 4;
  endfunction

  // Reference rule: aligned and inside [BASE, BASE + 4*DEPTH) reads the word, else faults.
  function automatic void expectOf(input int inst, input logic [31:0] addr,
                                   output logic [31:0] d, output logic e);
    logic [31:0] off;
    off = addr - BASE;
    e = ((addr % 4) != 0) || ((off / 4) >= 32'(DEPTH));
    d = e ? 32'd0 : model[inst][off / 4];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: event not allowed or bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rndReady) begin
      for (int i = 0; i < NI; i++) rReady[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic waitIdle(input int inst);
    int n;
    n = 0;
    while (!arReady[inst] && n < 200) begin
      tick();
      n++;
    end
    if (!arReady[inst]) reportFail($sformatf("idle_timeout[%0d]", inst));
  endtask

  task automatic preload(input int inst, input int idx, input logic [31:0] data);
    ldEn[inst]   = 1'b1;
    ldIdx[inst]  = 10'(idx);
    ldData[inst] = data;
    tick();
    ldEn[inst] = 1'b0;
    model[inst][idx] = data;
  endtask

  // Presents one address for a single cycle at a point where ar_ready is high,
  // so the handshake lands on the next edge (t0).
  task automatic applyStimulus(input int inst, input logic [31:0] addr,
                               input bit expectResp, output int t0);
    logic [31:0] d;
    logic        e;
    waitIdle(inst);
    arValid[inst] = 1'b1;
    arAddr[inst]  = addr;
    t0 = cyc + 1;
    if (expectResp) begin
      expectOf(inst, addr, d, e);
      sbq.push_back('{inst, d, e, t0 + latOf(inst)});
    end
    tick();
    arValid[inst] = 1'b0;
    checkOutput($sformatf("ar_ready_after_accept[%0d]", inst), 32'(arReady[inst]), 32'd0);
  endtask

  // Monitor: on each R beat compare against the oldest expectation; pop on handshake.
  initial begin
    bit prevV [NI];
    for (int i = 0; i < NI; i++) prevV[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < NI; i++) prevV[i] = 1'b0;
      end else begin
        for (int i = 0; i < NI; i++) begin
          if (rValid[i]) begin
            if (sbq.size() == 0) begin
              reportFail($sformatf("unexpected_rvalid[%0d]", i));
            end else begin
              if (!prevV[i]) begin
                checkOutput($sformatf("resp_inst[%0d]", i), 32'(sbq[0].inst), 32'(i));
                checkOutput($sformatf("rise_cycle[%0d]", i), 32'(cyc), 32'(sbq[0].riseCyc));
              end
              checkOutput($sformatf("r_data[%0d]", i), rData[i], sbq[0].data);
              checkOutput($sformatf("r_err[%0d]", i), 32'(rErr[i]), 32'(sbq[0].err));
              if (rReady[i]) void'(sbq.pop_front());
            end
          end
          prevV[i] = rValid[i];
        end
      end
    end
  end

  initial begin
    int t0;
    int t1;
    logic [31:0] addr;
    logic [31:0] errAddrs [3];

    for (int i = 0; i < NI; i++) begin
      arValid[i] = 1'b0;
      arAddr[i]  = 32'd0;
      rReady[i]  = 1'b1;
      ldEn[i]    = 1'b0;
      ldIdx[i]   = 10'd0;
      ldData[i]  = 32'd0;
    end

    // Reset, with ar_valid asserted on one instance to show it is ignored.
    arValid[0] = 1'b1;
    arAddr[0]  = BASE;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset_r_valid[%0d]", i), 32'(rValid[i]), 32'd0);
      checkOutput($sformatf("reset_r_data[%0d]", i), rData[i], 32'd0);
      checkOutput($sformatf("reset_r_err[%0d]", i), 32'(rErr[i]), 32'd0);
    end
    arValid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++)
      checkOutput($sformatf("reset_ar_ready[%0d]", i), 32'(arReady[i]), 32'd1);

    $display("[TB] preloading images");
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < NI; i++) begin
        ldEn[i]   = 1'b1;
        ldIdx[i]  = 10'(k);
        ldData[i] = (k == 0) ? 32'h0000_0413 : (k == 1) ? 32'h0010_0093 : $urandom;
        model[i][k] = ldData[i];
      end
      tick();
    end
    for (int i = 0; i < NI; i++) ldEn[i] = 1'b0;

    $display("[TB] LATENCY=1 back-to-back fetches");
    applyStimulus(0, BASE, 1'b1, t0);
    applyStimulus(0, BASE + 32'd4, 1'b1, t1);
    checkOutput("accept_spacing_lat1", 32'(t1 - t0), 32'd3);
    waitIdle(0);

    $display("[TB] LATENCY=4 with r_ready held low");
    rReady[2] = 1'b0;
    applyStimulus(2, BASE, 1'b1, t0);
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold_r_valid", 32'(rValid[2]), 32'd1);
      checkOutput("hold_ar_ready", 32'(arReady[2]), 32'd0);
      tick();
    end
    rReady[2] = 1'b1;
    tick();
    checkOutput("release_ar_ready", 32'(arReady[2]), 32'd1);
    checkOutput("release_r_valid", 32'(rValid[2]), 32'd0);

    $display("[TB] faulting addresses");
    errAddrs[0] = 32'h8000_0002;
    errAddrs[1] = 32'h8000_1000;
    errAddrs[2] = 32'h7FFF_FFFC;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, errAddrs[k], 1'b1, t0);
      waitIdle(1);
    end
    applyStimulus(1, BASE, 1'b1, t0);
    waitIdle(1);

    $display("[TB] preload colliding with the response edge");
    applyStimulus(1, BASE, 1'b1, t0);
    tick();
    ldEn[1]   = 1'b1;
    ldIdx[1]  = 10'd0;
    ldData[1] = 32'hDEAD_BEEF;
    tick();
    ldEn[1] = 1'b0;
    model[1][0] = 32'hDEAD_BEEF;
    waitIdle(1);
    applyStimulus(1, BASE, 1'b1, t0);
    waitIdle(1);

    $display("[TB] address changes after accept");
    applyStimulus(2, BASE, 1'b1, t0);
    arAddr[2] = BASE + 32'd4;
    waitIdle(2);
    applyStimulus(0, BASE, 1'b1, t0);
    arAddr[0] = BASE + 32'd4;
    waitIdle(0);

    $display("[TB] reset while waiting");
    applyStimulus(2, BASE + 32'd4, 1'b0, t0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_r_valid", 32'(rValid[2]), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("postreset_r_valid", 32'(rValid[2]), 32'd0);
      checkOutput("postreset_ar_ready", 32'(arReady[2]), 32'd1);
    end
    applyStimulus(2, BASE, 1'b1, t0);
    waitIdle(2);

    $display("[TB] randomized traffic");
    rndReady = 1'b1;
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 3) == 0)
          preload(i, int'($urandom_range(0, DEPTH - 1)), $urandom);
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
          6:                addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
          7:                addr = BASE + 32'(4 * (DEPTH + $urandom_range(0, 999)));
          8:                addr = BASE - 32'(4 * (1 + $urandom_range(0, 100)));
          default:          addr = $urandom;
        endcase
        applyStimulus(i, addr, 1'b1, t0);
        waitIdle(i);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    rndReady = 1'b0;
    for (int i = 0; i < NI; i++) rReady[i] = 1'b1;
    repeat (10) tick();
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ifu_isram.md
Name: ifu_isram

Overview:
- Instruction-memory slave sitting directly upstream of the IFU.
- Serves the IFU fetch request over a SimpleBus-style read channel:
  - AR channel (address request).
  - R channel (data response).
- Holds program words in an internal array and returns them after a programmable fixed latency, so the IFU idle/wait fetch FSM can be exercised against realistic memory timing.
- Also provides a bench/loader write port for preloading the image.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words; power of two.
- LATENCY, 1, cycles from AR handshake to r_valid; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- ar_valid  in  1  IFU presents a fetch address.
- ar_ready  out  1  slave can accept an address.
- ar_addr  in  32  byte address (the PC).
- r_valid  out  1  response data valid.
- r_ready  in  1  IFU accepts the response.
- r_data  out  32  instruction word.
- r_err  out  1  access fault (misaligned or out of range).
- ld_en  in  1  preload write enable.
- ld_idx  in  clog2(DEPTH)  preload word index.
- ld_data  in  32  preload word.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: r_valid=0, r_data=0, r_err=0; ar_ready=1 once rst_n deasserts.
  - Internal state: state=IDLE, cnt=0.
  - Memory array is not cleared.
  - Reset mid-transaction silently drops the transaction; no response is ever produced for it.
- FSM states: IDLE, WAIT, RESP. ar_ready = (state==IDLE), combinational from state.
- IDLE:
  - On ar_valid&&ar_ready at edge t0: latch ar_addr, cnt<=LATENCY-1, go WAIT.
  - ar_addr changes after t0 are ignored.
- WAIT:
  - If cnt==0: go RESP, r_valid<=1, and load r_data/r_err per the address check below.
  - Else: cnt<=cnt-1.
  - Timing: r_valid first high after edge t0+LATENCY.
- RESP:
  - r_valid, r_data and r_err are held stable while r_ready=0 (no timeout).
  - On r_valid&&r_ready: r_valid<=0, r_err<=0, go IDLE.
  - r_data keeps its last value after the handshake.
- Address check, evaluated on the latched address:
  - off = addr-BASE (32-bit wrap arithmetic).
  - Error if addr[1:0]!=0 or off[31:2] >= DEPTH. Addresses below BASE wrap to large off and are therefore errors.
  - On error: r_err=1, r_data=0.
  - Otherwise: r_err=0, r_data=mem[off[31:2]].
- Throughput:
  - No new request is accepted in WAIT or RESP.
  - Minimum request spacing is LATENCY+2 cycles with r_ready tied high. LATENCY=1 gives accepts at edges t0, t0+3, t0+6.
- Preload port:
  - ld_en writes mem[ld_idx]<=ld_data at the rising edge, in any FSM state.
  - If a write to the same index lands on the WAIT->RESP edge, the response carries the old word (read-before-write).
  - An earlier write is visible in the response.
- ar_valid high during reset is ignored.
- ar_valid may drop without a handshake; no state change results.

Test Plan:
- Preload mem[0]=32'h0000_0413 and mem[1]=32'h0010_0093; LATENCY=1; r_ready=1; fetch 0x8000_0000 -> r_valid high exactly 1 cycle after the AR handshake with r_data=32'h0000_0413 and r_err=0. A fetch of 0x8000_0004 is accepted 3 cycles after the first and returns 32'h0010_0093.
- LATENCY=4; fetch 0x8000_0000; hold r_ready=0 for 5 cycles -> r_valid rises 4 cycles after the handshake, stays high with a constant r_data for all 5 cycles, and ar_ready stays 0 throughout. Raising r_ready completes the transfer and ar_ready returns to 1 the next cycle.
- Fetch 0x8000_0002 (misaligned), then 0x8000_1000 (word 1024, past DEPTH=1024), then 0x7FFF_FFFC (below BASE) -> each responds with r_err=1 and r_data=0. The next fetch of 0x8000_0000 returns r_err=0.
- LATENCY=2; assert ld_en to index 0 with 32'hDEAD_BEEF on the WAIT->RESP edge of a fetch to 0x8000_0000 -> that response returns the old word. An immediate re-fetch returns 32'hDEAD_BEEF.
- Pull rst_n low asynchronously between two clock edges while in WAIT, then release -> r_valid drops immediately, no response appears, ar_ready=1 after release, and a new fetch completes normally with the memory contents intact.
- Change ar_addr to 0x8000_0004 during WAIT after accepting 0x8000_0000 -> the response is mem[0], not mem[1].
